// File: rtl/mem_pkg.sv
// Shared types and default constants for the mem_master single-outstanding memory client.
package mem_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MEM_SIZE   = 16;
    localparam int DEF_TIMEOUT    = 4;

    // Command fields are sized for the widest supported configuration; users slice them down.
    localparam int CMD_ADDR_MAX = 32;
    localparam int CMD_DATA_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic                    write;
        logic [CMD_ADDR_MAX-1:0] addr;
        logic [CMD_DATA_MAX-1:0] wdata;
    } cmd_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive WAIT cycles; expired flags the TIMEOUT-th ticked cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    assign expired = tick && (count_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || start) begin
            count_reg <= '0;
        end else if (tick && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_master.sv
// Single-outstanding memory master: IDLE -> ISSUE -> WAIT -> RESP with write timeout and statistics.
// Optional build macro MEM_MASTER_RANGE_CHECK_EN rejects addresses >= MEM_SIZE without touching memory.
module mem_master
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_response,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic [15:0]           err_count
);

    state_t                state_reg, state_next;
    cmd_t                  cmd_reg, cmd_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  timer_start, timer_tick, timer_expired;
    logic                  rsp_done;
    logic [2:0]            count_inc;
    logic [15:0]           count_reg [3];

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_reg       <= cmd_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cmd_next       = cmd_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        timer_start    = 1'b0;
        timer_tick     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_next.write = cmd_write;
                    cmd_next.addr  = CMD_ADDR_MAX'(cmd_addr);
                    cmd_next.wdata = CMD_DATA_MAX'(cmd_wdata);
                    state_next     = ST_ISSUE;
`ifdef MEM_MASTER_RANGE_CHECK_EN
                    // Out-of-range commands never reach the memory.
                    if (32'(cmd_addr) >= MEM_SIZE) begin
                        state_next     = ST_RESP;
                        rsp_rdata_next = '0;
                        rsp_err_next   = 1'b1;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                timer_start = 1'b1;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                timer_tick = 1'b1;
                if (!cmd_reg.write) begin
                    // Memory read latency is a fixed single cycle.
                    rsp_rdata_next = mem_rdata;
                    rsp_err_next   = 1'b0;
                    state_next     = ST_RESP;
                end else if (mem_response) begin
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b0;
                    state_next     = ST_RESP;
                end else if (timer_expired) begin
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign mem_wr    = (state_reg == ST_ISSUE) && cmd_reg.write;
    assign mem_rd    = (state_reg == ST_ISSUE) && !cmd_reg.write;
    assign mem_addr  = cmd_reg.addr[ADDR_WIDTH-1:0];
    assign mem_wdata = cmd_reg.wdata[DATA_WIDTH-1:0];

    // Statistics advance when the client takes the response.
    assign rsp_done     = (state_reg == ST_RESP) && rsp_ready;
    assign count_inc[0] = rsp_done && !rsp_err_reg && cmd_reg.write;
    assign count_inc[1] = rsp_done && !rsp_err_reg && !cmd_reg.write;
    assign count_inc[2] = rsp_done && rsp_err_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_count
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg[gi] <= '0;
                end else if (count_inc[gi]) begin
                    count_reg[gi] <= sat_inc(count_reg[gi]);
                end
            end
        end
    endgenerate

    assign wr_count  = count_reg[0];
    assign rd_count  = count_reg[1];
    assign err_count = count_reg[2];

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory data width.
REQ-003 SHALL have parameter MEM_SIZE, default 16, number of addressable words.
REQ-004 SHALL have parameter TIMEOUT, default 4, max WAIT cycles for write response.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  client command present.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at an edge.
REQ-009 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports cmd_addr  input  ADDR_WIDTH and cmd_wdata  input  DATA_WIDTH  command address and write data.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_rdata  output  DATA_WIDTH, rsp_err  output  1  completion channel.
REQ-012 SHALL have ports mem_wr, mem_rd  output  1 and mem_addr  output  ADDR_WIDTH, mem_wdata  output  DATA_WIDTH  memory request.
REQ-013 SHALL have ports mem_rdata  input  DATA_WIDTH and mem_response  input  1  memory read data and write acknowledge.
REQ-014 SHALL have ports wr_count, rd_count, err_count  output  16  transaction statistics.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one transaction outstanding.
REQ-016 SHALL assert cmd_ready only in IDLE; on accept, latch cmd_write/cmd_addr/cmd_wdata and enter ISSUE.
REQ-017 SHALL, in ISSUE (exactly one cycle), drive mem_addr/mem_wdata from latched values with mem_wr=cmd_write, mem_rd=!cmd_write, then enter WAIT.
REQ-018 SHALL hold mem_wr and mem_rd low in every state other than ISSUE.
REQ-019 SHALL, for a read, capture mem_rdata into rsp_rdata in the first WAIT cycle (fixed 1-cycle memory latency), rsp_err=0, enter RESP.
REQ-020 SHALL, for a write, leave WAIT for RESP with rsp_err=0 on the first WAIT cycle mem_response=1; rsp_rdata=0.
REQ-021 SHALL, for a write, enter RESP with rsp_err=1 if mem_response stays low for TIMEOUT consecutive WAIT cycles.
REQ-022 SHALL assert rsp_valid only in RESP, holding rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-023 SHALL give latency accept-edge to rsp_valid of 3 cycles (read, or write acked at first WAIT cycle).
REQ-024 SHALL increment wr_count/rd_count on each completed successful write/read and err_count on each error response, all saturating at 16'hFFFF.
REQ-025 SHALL ignore mem_response outside WAIT and cmd_* outside IDLE.

Reset
REQ-026 SHALL, on reset at any edge, force IDLE, mem_wr=mem_rd=0, mem_addr=mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all counters 0.
REQ-027 SHALL drop any in-flight transaction on reset without producing a response; cmd_ready=1 the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with MEM_MASTER_RANGE_CHECK_EN defined, route an accepted command with cmd_addr >= MEM_SIZE from IDLE directly to RESP with rsp_err=1, rsp_rdata=0, no mem_wr/mem_rd pulse, err_count incremented.
REQ-029 SHALL, without MEM_MASTER_RANGE_CHECK_EN, issue every address unchanged to the memory.

Structure
REQ-030 SHALL place the FSM state enum, default parameter constants and a command struct (write, addr, wdata) in shared package mem_pkg.
REQ-031 SHALL implement the WAIT timeout counter as sub-module mem_wait_timer (start, tick, expired).

Verification
REQ-032 SHALL cover write addr 3 data 16'hBEEF, responder acks next cycle -> mem_wr one cycle, rsp_valid 3 cycles after accept, rsp_err=0, wr_count=1.
REQ-033 SHALL cover read addr 3 after REQ-032 -> mem_rd one cycle, rsp_rdata=16'hBEEF, rsp_err=0, rd_count=1.
REQ-034 SHALL cover write with mem_response held low -> rsp_err=1 after 4 WAIT cycles, err_count=1.
REQ-035 SHALL cover rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready low throughout.
REQ-036 SHALL cover reset asserted during WAIT -> IDLE next cycle, no rsp_valid, counters 0.
REQ-037 SHALL cover, with MEM_MASTER_RANGE_CHECK_EN, read addr 8'd20 -> no mem_rd, rsp_err=1, rsp_rdata=0.
